// File: rtl/cam_pkg.sv
// cam_pkg: shared mode encodings, colour-bar table and byte-per-pixel helper
package cam_pkg;
  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_RAW8  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;
  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
  function automatic logic [1:0] bpp_of(input logic [1:0] m);
    return (m == MODE_RAW8) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/cam_pattern_pix.sv
// cam_pattern_pix: combinational test-pattern pixel for one (x, y, frame) coordinate
module cam_pattern_pix
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  mode,
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic [7:0]  f,
  input  logic [15:0] solid,
  output logic [15:0] pix
);
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [15:0] bar;
  logic [2:0]  idx;
  // pick the pattern value; bars past the eighth clamp to the last colour
  always_comb begin
    bar = x / 16'(BAR_W);
    idx = (bar > 16'd7) ? 3'd7 : bar[2:0];
    pix = (mode == MODE_BARS)  ? BAR_RGB[idx] :
          (mode == MODE_GRAD)  ? {x[4:0], y[5:0], f[4:0]} :
          (mode == MODE_RAW8)  ? {8'h00, x[7:0] + y + f} :
          (mode == MODE_SOLID) ? solid : 16'h0000;
  end
endmodule

// File: rtl/cam_timing_gen.sv
// cam_timing_gen: OV-style VSYNC/HREF/DATA source driven by built-in test patterns
module cam_timing_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 784,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 510,
  parameter int V_SYNC_LEN = 3,
  parameter int V_START    = 20,
  parameter int FCNT_W     = 16
) (
  input  logic              PCLK,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [15:0]       solid_rgb,
  output logic              VSYNC,
  output logic              HREF,
  output logic [7:0]        DATA,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;
  logic [0:0]    state;
  logic          phase;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic [1:0]    frame_mode;
  logic [15:0]   frame_solid;
  logic [15:0]   pix;
  logic [31:0]   hc, vc;
  logic          run, p_last, h_last, v_last, frame_end, active;
  logic [7:0]    byte_sel;
  assign hc        = 32'(h_count);
  assign vc        = 32'(v_count);
  assign run       = state == STATE_RUN;
  assign p_last    = phase || (bpp_of(frame_mode) == 2'd1);
  assign h_last    = hc == H_TOTAL - 1;
  assign v_last    = vc == V_TOTAL - 1;
  assign frame_end = run && p_last && h_last && v_last;
  assign active    = hc < H_ACTIVE && vc >= V_START && vc < V_START + V_ACTIVE;
  assign byte_sel  = p_last ? pix[7:0] : pix[15:8];
  cam_pattern_pix #(.H_ACTIVE(H_ACTIVE)) u_pix (
    .mode  (frame_mode),
    .x     (16'(h_count)),
    .y     (8'(vc - 32'(V_START))),
    .f     (8'(frame_cnt)),
    .solid (frame_solid),
    .pix   (pix)
  );
  // frame FSM and raster counters; frame settings only latch at a frame boundary
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      state       <= STATE_IDLE;
      phase       <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      frame_mode  <= MODE_BARS;
      frame_solid <= '0;
      frame_cnt   <= '0;
    end else if (!run) begin
      if (en) begin
        state       <= STATE_RUN;
        frame_mode  <= mode;
        frame_solid <= solid_rgb;
      end
    end else begin
      phase <= !p_last;
      if (p_last) h_count <= h_last ? '0 : h_count + 1'b1;
      if (p_last && h_last) v_count <= v_last ? '0 : v_count + 1'b1;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
        state     <= en ? STATE_RUN : STATE_IDLE;
        if (en) begin
          frame_mode  <= mode;
          frame_solid <= solid_rgb;
        end
      end
    end
  end
  // registered bus outputs, one cycle behind the counters
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      VSYNC       <= 1'b0;
      HREF        <= 1'b0;
      DATA        <= 8'h00;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      VSYNC       <= run && vc < V_SYNC_LEN;
      HREF        <= run && active;
      DATA        <= (run && active) ? byte_sel : 8'h00;
      frame_start <= run && h_count == '0 && v_count == '0 && !phase;
      busy        <= run;
    end
  end
endmodule

// File: tb/tb_cam_timing_gen.sv
// tb_cam_timing_gen: scoreboard bench for the camera timing generator
module tb_cam_timing_gen;
  logic        PCLK = 1'b0;
  logic        reset_n, en;
  logic [1:0]  mode;
  logic [15:0] solid_rgb;
  logic        VSYNC, HREF, frame_start, busy;
  logic [7:0]  DATA;
  logic [15:0] frame_cnt;
  logic [1:0]  pm;
  logic [15:0] px, ppix;
  logic [7:0]  py, pf;
  int tests = 0, fails = 0, cyc = 0, last_fs = -1;
  int exp_fs_period = 0, exp_vs_len = 0, exp_href_len = 0;
  int href_run = 0, vs_run = 0;
  logic [7:0]  q[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 PCLK = ~PCLK;

  cam_timing_gen #(
    .H_ACTIVE(16), .H_TOTAL(20), .V_ACTIVE(4), .V_TOTAL(8),
    .V_SYNC_LEN(1), .V_START(2), .FCNT_W(16)
  ) dut (
    .PCLK(PCLK), .reset_n(reset_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  cam_pattern_pix #(.H_ACTIVE(640)) u_pat (
    .mode(pm), .x(px), .y(py), .f(pf), .solid(16'h1234), .pix(ppix)
  );

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vsync"}, VSYNC, 0);
    chk({tag, "_href"}, HREF, 0);
    chk({tag, "_data"}, DATA, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic push_frame(input int m, input int f, input logic [15:0] s);
    logic [15:0] p;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 16; x++) begin
        if (m == 2) q.push_back(8'((x + y + f) % 256));
        else begin
          p = (m == 0) ? bars[x / 2] : s;
          q.push_back(p[15:8]);
          q.push_back(p[7:0]);
        end
      end
  endtask

  task automatic wait_fs(input int bound);
    int n = 0;
    logic seen = 1'b0;
    while (n < bound && !seen) begin
      @(negedge PCLK);
      if (frame_start) seen = 1'b1;
      n++;
    end
    chk("fs_arrived", seen, 1);
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_busy_low(input int bound, output int at);
    int n = 0;
    at = -1;
    while (n < bound && at < 0) begin
      @(negedge PCLK);
      if (!busy) at = cyc;
      n++;
    end
    chk("busy_dropped", at >= 0, 1);
  endtask

  // monitor: pops expected bytes on HREF and measures run lengths and frame spacing
  always @(negedge PCLK) begin
    if (HREF) begin
      href_run++;
      if (q.size() == 0) chk("data_unexpected", DATA, -1);
      else chk("data", DATA, q.pop_front());
    end else begin
      if (href_run != 0 && exp_href_len != 0) chk("href_len", href_run, exp_href_len);
      href_run = 0;
      if (DATA != 8'h00) chk("data_blank", DATA, 0);
    end
    if (VSYNC) vs_run++;
    else begin
      if (vs_run != 0 && exp_vs_len != 0) chk("vsync_len", vs_run, exp_vs_len);
      vs_run = 0;
    end
    if (frame_start) begin
      chk("fs_in_vsync", VSYNC && busy, 1);
      if (last_fs >= 0 && exp_fs_period != 0) chk("fs_period", cyc - last_fs, exp_fs_period);
      last_fs = cyc;
    end
  end

  initial begin
    int c0, t_fall, bad, n;
    reset_n = 1'b0; en = 1'b0; mode = 2'd0; solid_rgb = 16'h0000;
    pm = 2'd0; px = 16'd0; py = 8'd0; pf = 8'd0;
    tick(3);
    @(negedge PCLK);
    check_zero("reset");
    @(posedge PCLK); #1;
    reset_n = 1'b1;
    tick(3);
    @(negedge PCLK);
    chk("idle_busy", busy, 0);
    chk("idle_vsync", VSYNC, 0);
    @(posedge PCLK); #1;
    push_frame(0, 0, 16'h0); push_frame(0, 1, 16'h0);
    exp_vs_len = 40; exp_href_len = 32;
    en = 1'b1; c0 = cyc;
    wait_fs(10);
    chk("fs_latency", last_fs - c0, 2);
    chk("fcnt_f0", frame_cnt, 0);
    exp_fs_period = 320;
    wait_fs(400);
    chk("fcnt_f1", frame_cnt, 1);
    tick(100);
    mode = 2'd2;
    push_frame(2, 2, 16'h0); push_frame(2, 3, 16'h0);
    wait_fs(400);
    chk("fcnt_f2", frame_cnt, 2);
    exp_fs_period = 160; exp_vs_len = 20; exp_href_len = 16;
    wait_fs(200);
    chk("fcnt_f3", frame_cnt, 3);
    tick(50);
    mode = 2'd3; solid_rgb = 16'hA5C3;
    push_frame(3, 4, 16'hA5C3);
    wait_fs(200);
    chk("fcnt_f4", frame_cnt, 4);
    exp_fs_period = 0; exp_vs_len = 40; exp_href_len = 32;
    tick(100);
    en = 1'b0;
    wait_busy_low(400, t_fall);
    chk("busy_fall", t_fall - last_fs, 320);
    chk("fcnt_stop", frame_cnt, 5);
    bad = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (VSYNC || HREF || DATA != 8'h00 || busy || frame_start) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("fcnt_hold", frame_cnt, 5);
    @(posedge PCLK); #1;
    push_frame(3, 5, 16'hA5C3);
    en = 1'b1; c0 = cyc;
    wait_fs(10);
    chk("fs_relatch", last_fs - c0, 2);
    n = 0;
    while (!HREF && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    chk("href_seen", HREF, 1);
    tick(5);
    exp_href_len = 0;
    reset_n = 1'b0;
    @(posedge PCLK); #1;
    reset_n = 1'b1;
    q.delete();
    c0 = cyc;
    push_frame(3, 0, 16'hA5C3);
    @(negedge PCLK);
    check_zero("rst_mid");
    wait_fs(10);
    chk("fs_restart", last_fs - c0, 2);
    chk("fcnt_restart0", frame_cnt, 0);
    exp_href_len = 32;
    tick(100);
    en = 1'b0;
    wait_busy_low(400, t_fall);
    chk("busy_fall2", t_fall - last_fs, 320);
    chk("fcnt_restart1", frame_cnt, 1);
    chk("queue_drained", q.size(), 0);
    pm = 2'd1; px = 16'd3; py = 8'd2; pf = 8'd1; #1;
    chk("grad_pix", ppix, 16'h1841);
    pm = 2'd0; px = 16'd80; #1;
    chk("bar1_pix", ppix, 16'hFFE0);
    px = 16'd700; #1;
    chk("bar_clamp_pix", ppix, 16'h0000);
    pm = 2'd2; px = 16'd250; py = 8'd3; pf = 8'd4; #1;
    chk("raw8_wrap_pix", ppix, 16'h0001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cam_timing_gen.md
Name: cam_timing_gen

Overview:
- Synthesizable, parametrised camera-interface source: generates VSYNC/HREF/DATA timing and byte-serial pixel data on an OV-style bus.
- Pixels come from built-in test patterns, not a memory image.
- Used on the prototype board and in benches to drive the capture path without a sensor.
- Supports configurable geometry, 1- or 2-byte pixels, several pattern modes, a frame-level enable and frame counting.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- H_TOTAL, 784, total pixels per line including blanking; must be > H_ACTIVE.
- V_ACTIVE, 480, active lines per frame.
- V_TOTAL, 510, total lines per frame; must be ≥ V_START+V_ACTIVE.
- V_SYNC_LEN, 3, lines with VSYNC asserted, starting at line 0.
- V_START, 20, first active line; must be ≥ V_SYNC_LEN.
- FCNT_W, 16, frame counter width.

Ports:
- PCLK  in  1  pixel-bus clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- en  in  1  generation enable; sampled only at frame boundary.
- mode  in  2  pattern select; 0 colour bars RGB565, 1 gradient RGB565, 2 RAW8 ramp, 3 solid RGB565.
- solid_rgb  in  16  colour for mode 3.
- VSYNC  out  1  frame sync, active high.
- HREF  out  1  line valid, active high.
- DATA  out  8  pixel byte.
- frame_start  out  1  one-cycle pulse on the first VSYNC cycle of each frame.
- frame_cnt  out  FCNT_W  number of completed frames; wraps.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset: reset_n low at a PCLK edge clears all state. VSYNC=0, HREF=0, DATA=8'h00, frame_start=0, frame_cnt=0, busy=0, all counters 0, state IDLE. Reset mid-frame aborts the frame immediately.
- Bytes per pixel: BPP=2 for modes 0, 1, 3; BPP=1 for mode 2.
- Counters:
  - phase counts 0..BPP-1.
  - h_count advances when phase=BPP-1 and wraps at H_TOTAL-1.
  - v_count advances on h wrap and wraps at V_TOTAL-1.
  - A line therefore lasts H_TOTAL*BPP cycles.
- FSM:
  - IDLE: counters held at 0, outputs 0. If en=1, latch mode/solid_rgb as frame_mode/frame_solid and go to RUN.
  - RUN: counters advance every cycle.
  - Frame end is the cycle where v, h and phase are all at maximum. On that cycle frame_cnt increments; if en=1, re-latch mode and stay in RUN (back-to-back frames, no gap); else go to IDLE.
  - Deasserting en mid-frame never truncates a frame.
- Output latency: outputs are registered and reflect counter state one cycle earlier.
  - VSYNC = (v_count < V_SYNC_LEN).
  - HREF = (h_count < H_ACTIVE) && (V_START ≤ v_count < V_START+V_ACTIVE).
  - busy = state==RUN.
  - frame_start = 1 for the registered cycle of v=0, h=0, phase=0 in RUN.
- DATA: 8'h00 whenever HREF=0. For 2-byte modes, phase 0 sends pix[15:8] and phase 1 sends pix[7:0].
- Pixel coordinates: x=h_count, y=v_count-V_START, f=frame_cnt.
  - mode 0: 8 bars, each H_ACTIVE/8 pixels wide, bar index = x/(H_ACTIVE/8) clamped to 7. Bar colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 1: pix = {x[4:0], y[5:0], f[4:0]}.
  - mode 2: DATA = (x + y + f) mod 256.
  - mode 3: pix = frame_solid.
- Width rules: counters are sized by $clog2 of the respective totals; the mode 2 sum is truncated to 8 bits.
- Inputs that change mid-frame have no effect until the next frame boundary.

Decomposition:
- Shared package cam_pkg holds:
  - mode encodings (MODE_BARS, MODE_GRAD, MODE_RAW8, MODE_SOLID);
  - the 8-entry colour-bar RGB565 constant array;
  - the function bpp_of(mode).
- One combinational sub-module, cam_pattern_pix (inputs mode, x, y, f, solid; output 16-bit pix). The top handles counters, FSM, byte select and output registers.

Test Plan:
- Small params (H_ACTIVE=16, H_TOTAL=20, V_ACTIVE=4, V_TOTAL=8, V_SYNC_LEN=1, V_START=2), mode 0, en=1 after reset -> per frame, VSYNC high exactly 40 cycles, HREF high 4 lines × 32 cycles; first line bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF,…,00,00; frame_start pulses every 320 cycles.
- Same params, mode 2 -> HREF high 16 cycles/line, line length 20 cycles; in frame 0, line y=1 DATA = 01,02,…,10; frame 1 values offset by +1; frame_cnt=1 after first frame.
- Mode 3, solid_rgb=16'hA5C3 -> active bytes alternate A5,C3; DATA=00 in blanking; mode changed to 2 mid-frame takes effect only at next frame_start.
- en dropped mid-frame -> current frame completes, busy falls the cycle after the last frame cycle, outputs stay 0, frame_cnt increments once; en reasserted -> frame_start 1 cycle after latch.
- reset_n low for 1 cycle mid-active-line -> next cycle all outputs 0, frame_cnt=0, state IDLE; generation restarts cleanly from v=0 if en=1.
- Default params, mode 1, 2 frames -> line = 1568 cycles, frame = 799680 cycles, 307200 pixels per frame, gradient pixel at (x=3, y=2, f=1) = 16'h1841.
